clz_clo_seq: RTL and testbench

CLZ_CLO_SEQ -- requirements
Module: clz_clo_seq

---
 rtl/clz_clo_seq_pkg.sv | 17 +
 rtl/clz_clo_seq_count_bit_byte.sv | 23 ++
 rtl/clz_clo_seq.sv | 93 +++++++++
 tb/tb_clz_clo_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/clz_clo_seq_pkg.sv
// Shared EX-stage definitions for the sequential leading-bit counter:
// FSM encoding, widths and the byte-full constant.
package clz_clo_seq_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_W     = 8;
  localparam int RESULT_W   = 6;
  localparam int BYTE_CNT_W = 4;

  localparam logic [BYTE_CNT_W-1:0] BYTE_FULL = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/clz_clo_seq_count_bit_byte.sv
// Combinational leading-bit counter for one byte: leading zeros, or leading
// ones when op_clo is set. Output is 0..8.
module count_bit_byte
  import clz_clo_seq_pkg::*;
(
  input  logic [BYTE_W-1:0]     byte_in,
  input  logic                  op_clo,
  output logic [BYTE_CNT_W-1:0] cnt
);

  logic [BYTE_W-1:0] scan_val;

  // Counting leading ones is counting leading zeros of the inverted byte.
  // The highest set bit is the last match in the LSB-to-MSB loop.
  always_comb begin
    scan_val = op_clo ? ~byte_in : byte_in;
    cnt      = BYTE_FULL;
    for (int i = 0; i < BYTE_W; i++) begin
      if (scan_val[i]) cnt = BYTE_CNT_W'(BYTE_W - 1 - i);
    end
  end

endmodule

// File: rtl/clz_clo_seq.sv
// Multi-cycle CLZ/CLO unit: scans the latched word one byte per cycle from
// the MSB byte, stopping at the first non-full byte or after the last byte.
module clz_clo_seq
  import clz_clo_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op_clo,
  input  logic [WORD_W-1:0]   operand,
  input  logic                flush,
  output logic                busy,
  output logic                done,
  output logic [RESULT_W-1:0] result
);

  state_e                state_q, state_d;
  logic [WORD_W-1:0]     opnd_q;
  logic                  clo_q;
  logic [RESULT_W-1:0]   acc_q;
  logic [1:0]            idx_q;
  logic [BYTE_W-1:0]     byte_sel;
  logic [BYTE_CNT_W-1:0] cnt;
  logic [RESULT_W-1:0]   sum;
  logic                  accept;
  logic                  advance;
  logic                  finish;

  always_comb begin
    byte_sel = opnd_q[7:0];
    case (idx_q)
      2'd3:    byte_sel = opnd_q[31:24];
      2'd2:    byte_sel = opnd_q[23:16];
      2'd1:    byte_sel = opnd_q[15:8];
      default: byte_sel = opnd_q[7:0];
    endcase
  end

  count_bit_byte u_count (
    .byte_in (byte_sel),
    .op_clo  (clo_q),
    .cnt     (cnt)
  );

  // acc_q is at most 24 here, so acc + 8 stays within 6 bits (max 32).
  assign sum = acc_q + {{(RESULT_W-BYTE_CNT_W){1'b0}}, cnt};

  assign accept  = (state_q == IDLE) && start && !flush;
  assign advance = (state_q == SCAN) && !flush && (cnt == BYTE_FULL) && (idx_q != 2'd0);
  assign finish  = (state_q == SCAN) && !flush && !((cnt == BYTE_FULL) && (idx_q != 2'd0));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = SCAN;
      SCAN: if (flush || finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_q <= '0;
      clo_q  <= 1'b0;
      acc_q  <= '0;
      idx_q  <= 2'd3;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        opnd_q <= operand;
        clo_q  <= op_clo;
        acc_q  <= '0;
        idx_q  <= 2'd3;
      end else if (advance) begin
        acc_q <= acc_q + {{(RESULT_W-BYTE_CNT_W){1'b0}}, BYTE_FULL};
        idx_q <= idx_q - 2'd1;
      end else if (finish) begin
        result <= sum;
        done   <= 1'b1;
      end
    end
  end

  assign busy = (state_q == SCAN);

endmodule

// File: tb/tb_clz_clo_seq.sv
// Self-checking bench for clz_clo_seq: directed corner cases plus randomized
// operands compared against a bit-serial reference count.
module tb_clz_clo_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op_clo;
  logic [31:0] operand;
  logic        flush;
  logic        busy;
  logic        done;
  logic [5:0]  result;

  int tests = 0;
  int fails = 0;

  clz_clo_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_clo  (op_clo),
    .operand (operand),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  function automatic int ref_count(logic [31:0] w, logic clo);
    int n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (w[i] != clo) break;
      n++;
    end
    return n;
  endfunction

  function automatic int ref_cycles(int n);
    return (n >= 32) ? 4 : (n / 8 + 1);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where busy has dropped.
  task automatic run_op(input string tag, input logic [31:0] w, input logic clo,
                        input int exp_res, input int exp_cyc);
    int cyc;
    start   = 1'b1;
    op_clo  = clo;
    operand = w;
    flush   = 1'b0;
    @(negedge clk);
    start   = 1'b0;
    operand = $urandom;
    cyc = 0;
    while (busy === 1'b1 && cyc < 10) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, ".cycles"}, cyc, exp_cyc);
    check({tag, ".done"}, int'(done), 1);
    check({tag, ".result"}, int'(result), exp_res);
  endtask

  initial begin
    logic [31:0] w;
    logic        clo;
    int          n;
    int          saw_done;

    rst_n = 1'b0; start = 1'b0; op_clo = 1'b0; operand = '0; flush = 1'b0;
    #7;
    check("reset.busy", int'(busy), 0);
    check("reset.done", int'(done), 0);
    check("reset.result", int'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("clz_00010000", 32'h0001_0000, 1'b0, 15, 2);
    run_op("clz_zero", 32'h0000_0000, 1'b0, 32, 4);
    run_op("clo_fffffff0", 32'hFFFF_FFF0, 1'b1, 28, 4);

    // Flush in the 2nd scan cycle; a start during busy must be ignored.
    start = 1'b1; op_clo = 1'b0; operand = 32'h0000_0000;
    @(negedge clk);
    operand = 32'hFFFF_FFFF;
    check("flush.busy1", int'(busy), 1);
    @(negedge clk);
    start = 1'b0;
    check("flush.busy2", int'(busy), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush.busy_after", int'(busy), 0);
    check("flush.no_done", int'(done), 0);
    check("flush.result_kept", int'(result), 28);
    @(negedge clk);
    check("flush.no_late_done", int'(done), 0);

    run_op("clo_7fffffff", 32'h7FFF_FFFF, 1'b1, 0, 1);

    // Back-to-back: next start issued in the done cycle.
    run_op("b2b_first", 32'h0000_00FF, 1'b0, 24, 4);
    run_op("b2b_clz_80000000", 32'h8000_0000, 1'b0, 0, 1);
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);

    for (int k = 0; k < 40; k++) begin
      clo = 1'($urandom_range(0, 1));
      w   = $urandom >> $urandom_range(0, 32);
      if (clo) w = ~w;
      n = ref_count(w, clo);
      run_op($sformatf("rand%0d", k), w, clo, n, ref_cycles(n));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    // Start together with flush while idle is not accepted.
    start = 1'b1; flush = 1'b1; operand = 32'h0; op_clo = 1'b0;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("idle_flush.busy", int'(busy), 0);
    @(negedge clk);
    check("idle_flush.done", int'(done), 0);

    run_op("pre_reset", 32'h0000_0F00, 1'b0, 20, 3);

    // Reset asserted mid-scan clears outputs immediately.
    start = 1'b1; op_clo = 1'b0; operand = 32'h0000_0000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rst_mid.busy_before", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.busy", int'(busy), 0);
    check("rst_mid.done", int'(done), 0);
    check("rst_mid.result", int'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1;
    end
    check("rst_mid.no_done_after", saw_done, 0);

    run_op("post_reset", 32'h00F0_0000, 1'b0, 8, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
